alu_issue_ctrl: RTL and testbench
=================================

# alu_issue_ctrl

Issue controller and result buffer for the single shared integer ALU functional unit in the Tomasulo core. Arbitrates among N reservation-station entries whose operands are ready, drives the ALU's one-cycle EN/finish handshake, captures the result on finish, and holds it in a one-entry buffer until the common data bus (CDB) accepts it. Sits between the ALU reservation stations and the ALU, and presents a requester to the CDB arbiter.

## Interface
- N_RS, 4: number of requesting reservation-station entries (2..8)
- TAG_W, 3: width of the RS tag broadcast on the CDB
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- flush  in  1  synchronous squash (branch mispredict)
- req  in  N_RS  entry i has both operands ready
- req_op  in  4*N_RS  ALUControl code per entry
- req_a, req_b  in  32*N_RS  operands per entry
- req_tag  in  TAG_W*N_RS  tag per entry
- grant  out  N_RS  one-hot; entry i issued this cycle, must free itself
- alu_en  out  1  ALU EN
- alu_ctrl  out  4  ALU ALUControl
- alu_a, alu_b  out  32  ALU operands
- alu_res  in  32  ALU result
- alu_overflow  in  1  ALU overflow
- alu_finish  in  1  ALU finish
- cdb_valid  out  1  buffered result valid
- cdb_tag  out  TAG_W  tag of buffered result
- cdb_data  out  32  buffered result
- cdb_ovf  out  1  buffered overflow flag
- cdb_ready  in  1  CDB accepts result this cycle

## Operation
- FSM states IDLE, EXEC.
- Issue condition (IDLE only): `|req` and (`!cdb_valid` or `cdb_ready`) and `!flush`.
- IDLE, issue: select entry s (arbitration below); grant[s]=1, alu_en=1, and alu_ctrl/alu_a/alu_b/tag driven from entry s, all combinationally. Latch the tag into tag_q. Go to EXEC.
- IDLE, no issue: grant=0, alu_en=0, alu_a/alu_b/alu_ctrl=0. Stay.
- EXEC, alu_finish=1: load alu_res, alu_overflow, and tag_q into the buffer. Set cdb_valid. Go to IDLE.
- EXEC, alu_finish=0: stay in EXEC with alu_en=0. This is defensive only; the ALU always finishes next cycle.
- Buffer drain: cdb_valid & cdb_ready clears cdb_valid at the edge, unless a capture occurs on the same edge (capture wins and cdb_valid stays 1).
- flush: clears cdb_valid. In EXEC it forces IDLE and discards the ALU result. No grant is issued during a flush cycle.
- Operands and result pass through unmodified (32-bit). The block does no arithmetic.

## Timing
- Reset values: state=IDLE, cdb_valid=0, cdb_tag=0, cdb_data=0, cdb_ovf=0, rr pointer=0. grant, alu_en, and alu_* are 0.
- Issue in cycle t. ALU finish in t+1. cdb_valid=1 from t+2. Issue-to-CDB latency is 2 cycles.
- Maximum throughput is one issue every 2 cycles, matching the ALU's refusal of EN while finish is high.
- The buffer can never overflow. Issue is only allowed when the buffer is empty or draining, and a capture occurs exactly one cycle after issue.
- Reset asserted mid-EXEC: the in-flight result is lost. The ALU's own state clears on its next clock.

## Configuration
- ALU_ISSUE_RR_EN defined: round-robin arbitration. Search starts at the pointer; after a grant to s, the pointer becomes (s+1) mod N_RS. The pointer only changes on grant.
- Undefined: fixed priority, lowest index wins, and no pointer register exists.

## Structure
- Shared package tomasulo_pkg: ALU op localparams (ADD=1 … Bout=12), the FSM state enum, and the TAG_W default.
- Sub-module rr_arbiter (N, req, ptr → one-hot gnt, index). Round-robin vs fixed priority is selected inside it by ALU_ISSUE_RR_EN.

## Test plan
- Single issue: req=0001, op=ADD, a=5, b=7, tag=2, cdb_ready=1 → grant=0001 and alu_en in cycle t; cdb_valid, data=12, tag=2 in t+2 for one cycle.
- Back-to-back: req=1111 held, cdb_ready=1, RR enabled → grants 0001, 0010, 0100, 1000, 0001 on every other cycle. With RR disabled, grant stays 0001.
- Backpressure: cdb_ready=0 with a result buffered and req=0010 → no grant and data held stable. Raise cdb_ready → grant on that same cycle, and the new result appears 2 cycles later.
- Overflow: op=ADD, a=0x7FFFFFFF, b=1 → cdb_data=0x80000000, cdb_ovf=1. Then SUB 3−5 → 0xFFFFFFFE, cdb_ovf=0.
- Flush in EXEC: issue tag=5, assert flush at t+1 → cdb_valid stays 0 and state returns to IDLE. A flush concurrent with req yields no grant.
- Async reset mid-EXEC: drop rst_n between edges → cdb_valid=0 and alu_en=0 immediately. Next issue uses pointer 0.

Source files
------------

// File: rtl/tomasulo_pkg.sv
// Shared Tomasulo core definitions: ALU op codes, ALU issue FSM states, default tag width.
package tomasulo_pkg;

  localparam int TAG_W_DEFAULT = 3;

  localparam logic [3:0] ALU_ADD  = 4'd1;
  localparam logic [3:0] ALU_SUB  = 4'd2;
  localparam logic [3:0] ALU_AND  = 4'd3;
  localparam logic [3:0] ALU_OR   = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SLL  = 4'd6;
  localparam logic [3:0] ALU_SRL  = 4'd7;
  localparam logic [3:0] ALU_SRA  = 4'd8;
  localparam logic [3:0] ALU_SLT  = 4'd9;
  localparam logic [3:0] ALU_SLTU = 4'd10;
  localparam logic [3:0] ALU_AOUT = 4'd11;
  localparam logic [3:0] ALU_BOUT = 4'd12;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_EXEC = 1'b1
  } alu_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Request arbiter producing a one-hot grant and its index.
// Build option ALU_ISSUE_RR_EN: round-robin from ptr; otherwise fixed priority, lowest index wins.
module rr_arbiter
  import tomasulo_pkg::*;
#(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
`ifdef ALU_ISSUE_RR_EN
  input  logic [IDX_W-1:0] ptr,
`endif
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

`ifdef ALU_ISSUE_RR_EN
  // Scan from the farthest offset down so the entry closest to ptr wins.
  always_comb begin
    int cand;
    gnt  = {N{1'b0}};
    idx  = {IDX_W{1'b0}};
    any  = 1'b0;
    cand = 0;
    for (int k = N - 1; k >= 0; k--) begin
      cand = (int'(ptr) + k >= N) ? (int'(ptr) + k - N) : (int'(ptr) + k);
      if (req[cand]) begin
        gnt       = {N{1'b0}};
        gnt[cand] = 1'b1;
        idx       = IDX_W'(cand);
        any       = 1'b1;
      end else begin
        any = any;
      end
    end
  end
`else
  // Scan from the top down so the lowest requesting index wins.
  always_comb begin
    gnt = {N{1'b0}};
    idx = {IDX_W{1'b0}};
    any = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[k]) begin
        gnt    = {N{1'b0}};
        gnt[k] = 1'b1;
        idx    = IDX_W'(k);
        any    = 1'b1;
      end else begin
        any = any;
      end
    end
  end
`endif

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue controller and one-entry result buffer for the shared integer ALU.
// Build option ALU_ISSUE_RR_EN selects round-robin arbitration (fixed priority when undefined).
module alu_issue_ctrl
  import tomasulo_pkg::*;
#(
  parameter int N_RS  = 4,
  parameter int TAG_W = TAG_W_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic [N_RS-1:0]       req,
  input  logic [4*N_RS-1:0]     req_op,
  input  logic [32*N_RS-1:0]    req_a,
  input  logic [32*N_RS-1:0]    req_b,
  input  logic [TAG_W*N_RS-1:0] req_tag,
  output logic [N_RS-1:0]       grant,
  output logic                  alu_en,
  output logic [3:0]            alu_ctrl,
  output logic [31:0]           alu_a,
  output logic [31:0]           alu_b,
  input  logic [31:0]           alu_res,
  input  logic                  alu_overflow,
  input  logic                  alu_finish,
  output logic                  cdb_valid,
  output logic [TAG_W-1:0]      cdb_tag,
  output logic [31:0]           cdb_data,
  output logic                  cdb_ovf,
  input  logic                  cdb_ready
);

  localparam int IDX_W = (N_RS > 1) ? $clog2(N_RS) : 1;

  alu_state_e        state_r;
  alu_state_e        state_nxt_s;
  logic [N_RS-1:0]   arb_gnt_s;
  logic [IDX_W-1:0]  sel_idx_s;
  logic              arb_any_s;
  logic              issue_s;
  logic              capture_s;
  logic [TAG_W-1:0]  tag_r;
  logic              cdb_valid_r;
  logic [TAG_W-1:0]  cdb_tag_r;
  logic [31:0]       cdb_data_r;
  logic              cdb_ovf_r;

  // Issue only into an empty or draining buffer, so a capture can never overrun it.
  assign issue_s   = (state_r == ST_IDLE) && arb_any_s && (!cdb_valid_r || cdb_ready) && !flush;
  assign capture_s = (state_r == ST_EXEC) && alu_finish && !flush;

`ifdef ALU_ISSUE_RR_EN
  logic [IDX_W-1:0] ptr_r;

  // Round-robin pointer moves just past the winner, and only on a grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_r <= {IDX_W{1'b0}};
    end else if (issue_s) begin
      ptr_r <= (int'(sel_idx_s) == N_RS - 1) ? {IDX_W{1'b0}} : sel_idx_s + IDX_W'(1);
    end else begin
      ptr_r <= ptr_r;
    end
  end
`endif

  rr_arbiter #(
    .N     (N_RS),
    .IDX_W (IDX_W)
  ) u_arb (
    .req (req),
`ifdef ALU_ISSUE_RR_EN
    .ptr (ptr_r),
`endif
    .gnt (arb_gnt_s),
    .idx (sel_idx_s),
    .any (arb_any_s)
  );

  // Next state and the combinational ALU handshake.
  always_comb begin
    state_nxt_s = state_r;
    grant       = {N_RS{1'b0}};
    alu_en      = 1'b0;
    alu_ctrl    = 4'd0;
    alu_a       = 32'd0;
    alu_b       = 32'd0;
    case (state_r)
      ST_IDLE: begin
        if (issue_s) begin
          grant       = arb_gnt_s;
          alu_en      = 1'b1;
          alu_ctrl    = req_op[int'(sel_idx_s)*4 +: 4];
          alu_a       = req_a[int'(sel_idx_s)*32 +: 32];
          alu_b       = req_b[int'(sel_idx_s)*32 +: 32];
          state_nxt_s = ST_EXEC;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_EXEC: begin
        if (flush || alu_finish) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_EXEC;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Tag of the in-flight op, attached to its result at capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_r <= {TAG_W{1'b0}};
    end else if (issue_s) begin
      tag_r <= req_tag[int'(sel_idx_s)*TAG_W +: TAG_W];
    end else begin
      tag_r <= tag_r;
    end
  end

  // Result buffer: flush squashes, capture beats a same-edge drain, drain keeps data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cdb_valid_r <= 1'b0;
      cdb_tag_r   <= {TAG_W{1'b0}};
      cdb_data_r  <= 32'd0;
      cdb_ovf_r   <= 1'b0;
    end else if (flush) begin
      cdb_valid_r <= 1'b0;
    end else if (capture_s) begin
      cdb_valid_r <= 1'b1;
      cdb_tag_r   <= tag_r;
      cdb_data_r  <= alu_res;
      cdb_ovf_r   <= alu_overflow;
    end else if (cdb_ready) begin
      cdb_valid_r <= 1'b0;
    end else begin
      cdb_valid_r <= cdb_valid_r;
    end
  end

  assign cdb_valid = cdb_valid_r;
  assign cdb_tag   = cdb_tag_r;
  assign cdb_data  = cdb_data_r;
  assign cdb_ovf   = cdb_ovf_r;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a one-cycle ALU model; follows ALU_ISSUE_RR_EN.
module tb_alu_issue_ctrl;
  import tomasulo_pkg::*;

  localparam int N_RS  = 4;
  localparam int TAG_W = 3;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  flush;
  logic [N_RS-1:0]       req;
  logic [4*N_RS-1:0]     req_op;
  logic [32*N_RS-1:0]    req_a;
  logic [32*N_RS-1:0]    req_b;
  logic [TAG_W*N_RS-1:0] req_tag;
  logic [N_RS-1:0]       grant;
  logic                  alu_en;
  logic [3:0]            alu_ctrl;
  logic [31:0]           alu_a;
  logic [31:0]           alu_b;
  logic [31:0]           alu_res = 32'd0;
  logic                  alu_overflow = 1'b0;
  logic                  alu_finish = 1'b0;
  logic                  cdb_valid;
  logic [TAG_W-1:0]      cdb_tag;
  logic [31:0]           cdb_data;
  logic                  cdb_ovf;
  logic                  cdb_ready;

  int tests_run    = 0;
  int tests_failed = 0;

  alu_issue_ctrl #(.N_RS(N_RS), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .req(req), .req_op(req_op), .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
    .grant(grant), .alu_en(alu_en), .alu_ctrl(alu_ctrl), .alu_a(alu_a), .alu_b(alu_b),
    .alu_res(alu_res), .alu_overflow(alu_overflow), .alu_finish(alu_finish),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data), .cdb_ovf(cdb_ovf),
    .cdb_ready(cdb_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [32:0] alu_model(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    logic [31:0] r;
    logic        v;
    case (op)
      ALU_ADD: begin r = a + b; v = (a[31] == b[31]) && (r[31] != a[31]); end
      ALU_SUB: begin r = a - b; v = (a[31] != b[31]) && (r[31] != a[31]); end
      default: begin r = 32'd0; v = 1'b0; end
    endcase
    return {v, r};
  endfunction

  // One-cycle ALU: finish and result the cycle after EN.
  always @(posedge clk) begin
    alu_finish <= alu_en;
    if (alu_en) begin
      {alu_overflow, alu_res} <= alu_model(alu_ctrl, alu_a, alu_b);
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_entry(input int i, input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [TAG_W-1:0] tag);
    req_op[i*4 +: 4]          = op;
    req_a[i*32 +: 32]         = a;
    req_b[i*32 +: 32]         = b;
    req_tag[i*TAG_W +: TAG_W] = tag;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    flush = 1'b0;
    req   = 4'b0000;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  logic [3:0]  exp_g [5];
  logic [2:0]  exp_t [5];
  logic [31:0] exp_d [5];

  initial begin
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
    req_tag   = '0;
    cdb_ready = 1'b1;
    do_reset();
    #1;
    check_eq("rst_valid", 32'(cdb_valid), 32'd0);
    check_eq("rst_tag",   32'(cdb_tag),   32'd0);
    check_eq("rst_data",  cdb_data,       32'd0);
    check_eq("rst_ovf",   32'(cdb_ovf),   32'd0);
    check_eq("rst_grant", 32'(grant),     32'd0);
    check_eq("rst_alu_en", 32'(alu_en),   32'd0);

    // Single issue: ADD 5+7, tag 2.
    set_entry(0, ALU_ADD, 32'd5, 32'd7, 3'd2);
    req = 4'b0001;
    #1;
    check_eq("si_grant", 32'(grant),    32'h1);
    check_eq("si_en",    32'(alu_en),   32'd1);
    check_eq("si_ctrl",  32'(alu_ctrl), 32'd1);
    check_eq("si_a",     alu_a,         32'd5);
    check_eq("si_b",     alu_b,         32'd7);
    tick(); req = 4'b0000; #1;
    check_eq("si_exec_en",    32'(alu_en),    32'd0);
    check_eq("si_exec_valid", 32'(cdb_valid), 32'd0);
    tick(); #1;
    check_eq("si_valid", 32'(cdb_valid), 32'd1);
    check_eq("si_data",  cdb_data,       32'd12);
    check_eq("si_tag",   32'(cdb_tag),   32'd2);
    check_eq("si_ovf",   32'(cdb_ovf),   32'd0);
    tick(); #1;
    check_eq("si_drained", 32'(cdb_valid), 32'd0);

    // Back-to-back with req=1111 held; entry i computes 10*i+1 with tag i+1.
    do_reset();
    for (int i = 0; i < 4; i++) set_entry(i, ALU_ADD, 32'(10 * i), 32'd1, 3'(i + 1));
`ifdef ALU_ISSUE_RR_EN
    exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    exp_t = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd1};
    exp_d = '{32'd1, 32'd11, 32'd21, 32'd31, 32'd1};
`else
    exp_g = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
    exp_t = '{3'd1, 3'd1, 3'd1, 3'd1, 3'd1};
    exp_d = '{32'd1, 32'd1, 32'd1, 32'd1, 32'd1};
`endif
    req = 4'b1111;
    #1;
    for (int n = 0; n < 5; n++) begin
      check_eq("b2b_grant", 32'(grant), 32'(exp_g[n]));
      tick(); #1;
      check_eq("b2b_gap_grant", 32'(grant), 32'd0);
      tick(); #1;
      check_eq("b2b_valid", 32'(cdb_valid), 32'd1);
      check_eq("b2b_tag",   32'(cdb_tag),   32'(exp_t[n]));
      check_eq("b2b_data",  cdb_data,       exp_d[n]);
    end
    req = 4'b0000;
    tick(); #1;
    check_eq("b2b_drained", 32'(cdb_valid), 32'd0);

    // Backpressure: buffered result blocks issue until cdb_ready rises.
    do_reset();
    set_entry(0, ALU_ADD, 32'd5, 32'd7, 3'd2);
    set_entry(1, ALU_ADD, 32'd100, 32'd23, 3'd3);
    cdb_ready = 1'b0;
    req = 4'b0001;
    #1;
    check_eq("bp_first_grant", 32'(grant), 32'h1);
    tick(); req = 4'b0000;
    tick(); req = 4'b0010; #1;
    check_eq("bp_grant0",  32'(grant),     32'd0);
    check_eq("bp_valid0",  32'(cdb_valid), 32'd1);
    check_eq("bp_data0",   cdb_data,       32'd12);
    tick(); #1;
    check_eq("bp_grant1",  32'(grant),     32'd0);
    check_eq("bp_valid1",  32'(cdb_valid), 32'd1);
    check_eq("bp_data1",   cdb_data,       32'd12);
    cdb_ready = 1'b1; #1;
    check_eq("bp_release_grant", 32'(grant),  32'h2);
    check_eq("bp_release_en",    32'(alu_en), 32'd1);
    tick(); req = 4'b0000; #1;
    check_eq("bp_drained", 32'(cdb_valid), 32'd0);
    tick(); #1;
    check_eq("bp_new_valid", 32'(cdb_valid), 32'd1);
    check_eq("bp_new_data",  cdb_data,       32'd123);
    check_eq("bp_new_tag",   32'(cdb_tag),   32'd3);

    // Overflow flag pass-through.
    set_entry(2, ALU_ADD, 32'h7FFF_FFFF, 32'd1, 3'd6);
    req = 4'b0100; #1;
    check_eq("ovf_grant", 32'(grant), 32'h4);
    tick(); req = 4'b0000;
    tick(); #1;
    check_eq("ovf_data", cdb_data,     32'h8000_0000);
    check_eq("ovf_flag", 32'(cdb_ovf), 32'd1);
    check_eq("ovf_tag",  32'(cdb_tag), 32'd6);
    set_entry(3, ALU_SUB, 32'd3, 32'd5, 3'd7);
    req = 4'b1000; #1;
    check_eq("sub_grant", 32'(grant), 32'h8);
    tick(); req = 4'b0000;
    tick(); #1;
    check_eq("sub_data", cdb_data,     32'hFFFF_FFFE);
    check_eq("sub_flag", 32'(cdb_ovf), 32'd0);
    tick();

    // Flush during EXEC discards the result and returns to IDLE.
    set_entry(0, ALU_ADD, 32'd1, 32'd1, 3'd5);
    req = 4'b0001; #1;
    check_eq("fl_issue", 32'(grant), 32'h1);
    tick(); flush = 1'b1; #1;
    check_eq("fl_exec_grant", 32'(grant), 32'd0);
    tick(); flush = 1'b0; #1;
    check_eq("fl_valid",   32'(cdb_valid), 32'd0);
    check_eq("fl_reissue", 32'(grant),     32'h1);
    tick(); req = 4'b0000;
    tick(); #1;
    check_eq("fl_re_valid", 32'(cdb_valid), 32'd1);
    check_eq("fl_re_data",  cdb_data,       32'd2);
    check_eq("fl_re_tag",   32'(cdb_tag),   32'd5);
    cdb_ready = 1'b0;
    tick(); #1;
    check_eq("fl_hold_valid", 32'(cdb_valid), 32'd1);
    flush = 1'b1; req = 4'b0001; #1;
    check_eq("fl_idle_grant", 32'(grant),  32'd0);
    check_eq("fl_idle_en",    32'(alu_en), 32'd0);
    tick(); flush = 1'b0; req = 4'b0000; #1;
    check_eq("fl_buf_clear", 32'(cdb_valid), 32'd0);
    cdb_ready = 1'b1;

    // Asynchronous reset in EXEC loses the result and resets the pointer.
    set_entry(2, ALU_ADD, 32'd9, 32'd9, 3'd4);
    req = 4'b0100; #1;
    check_eq("ar_issue", 32'(grant), 32'h4);
    tick(); req = 4'b0000; #1;
    rst_n = 1'b0; #1;
    check_eq("ar_en",    32'(alu_en),    32'd0);
    check_eq("ar_valid", 32'(cdb_valid), 32'd0);
    check_eq("ar_data",  cdb_data,       32'd0);
    tick(); rst_n = 1'b1;
    tick(); #1;
    check_eq("ar_lost", 32'(cdb_valid), 32'd0);
    req = 4'b1111; #1;
    check_eq("ar_ptr0_grant", 32'(grant), 32'h1);
    tick(); req = 4'b0000;
    tick(); #1;
    check_eq("ar_post_valid", 32'(cdb_valid), 32'd1);
    check_eq("ar_post_tag",   32'(cdb_tag),   32'd5);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
